// File: rtl/gabor_scan_ctrl.sv
// gabor_scan_ctrl
// ---------------------------------------------------------------------------
// Sequencer for the 2-D Gabor convolution datapath.
//   1. On start it reads the KxK coefficient set from the kernel BRAMs.
//      The BRAMs share one address bus.
//   2. It walks every valid KxK window of the image BRAM in raster order.
//      Each window is assembled and offered to the datapath over valid/ready.
//   3. It turns returned results into output-BRAM write addresses.
//   4. It pulses done with the write of the last result.
//
// Ports
//   clk, rst               single rising-edge clock, async active-high reset
//   start                  one-cycle request, honoured only in IDLE
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse with the final output write
//   kern_addr              shared kernel BRAM address
//   kern_load / kern_idx   kernel data valid this cycle / coefficient index
//   img_addr / img_data    image BRAM read port (1-cycle read latency)
//   win_valid / win_ready  window handshake
//   win_pixels             window, element dr*K+dc at [i*PIX_W +: PIX_W]
//   res_valid              datapath result for the next output position
//   out_we / out_addr      output BRAM write port
// ---------------------------------------------------------------------------
module gabor_scan_ctrl #(
   parameter int IMAGE_WIDTH   = 512,
   parameter int IMAGE_HEIGHT  = 512,
   parameter int KERNEL_LENGTH = 5,
   parameter int PIX_W         = 8,
   parameter int ADDR_W        = 18,
   parameter int KADDR_W       = 5
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           start,
   output logic                                           busy,
   output logic                                           done,
   output logic [KADDR_W-1:0]                             kern_addr,
   output logic                                           kern_load,
   output logic [KADDR_W-1:0]                             kern_idx,
   output logic [ADDR_W-1:0]                              img_addr,
   input  logic [PIX_W-1:0]                               img_data,
   output logic                                           win_valid,
   input  logic                                           win_ready,
   output logic [PIX_W*KERNEL_LENGTH*KERNEL_LENGTH-1:0]   win_pixels,
   input  logic                                           res_valid,
   output logic                                           out_we,
   output logic [ADDR_W-1:0]                              out_addr
);

   localparam int K     = KERNEL_LENGTH;
   localparam int KK    = K * K;
   localparam int OUT_W = IMAGE_WIDTH - K + 1;
   localparam int OUT_H = IMAGE_HEIGHT - K + 1;
   localparam int TOTAL = OUT_W * OUT_H;
   localparam int WIN_W = PIX_W * KK;
   localparam int CNT_W = $clog2(KK + 1);
   localparam int COL_W = $clog2(OUT_W + 1);
   localparam int ROW_W = $clog2(OUT_H + 1);
   localparam int RES_W = $clog2(TOTAL + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KLOAD,
      S_FETCH,
      S_PRESENT,
      S_DRAIN
   } state_t;

   state_t              state_q,     state_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic [KADDR_W-1:0]  kern_addr_q, kern_addr_d;
   logic                kern_load_q, kern_load_d;
   logic [KADDR_W-1:0]  kern_idx_q,  kern_idx_d;
   logic [ADDR_W-1:0]   img_addr_q,  img_addr_d;
   logic                win_valid_q, win_valid_d;
   logic [WIN_W-1:0]    win_pix_q,   win_pix_d;
   logic                out_we_q,    out_we_d;
   logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
   // Step counter shared by KLOAD and FETCH; both phases run 0..KK.
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   // Column offset of the address currently on img_addr.
   logic [CNT_W-1:0]    dc_q,        dc_d;
   logic [COL_W-1:0]    col_q,       col_d;
   logic [ROW_W-1:0]    row_q,       row_d;
   // Image address of element 0 of the current window, row*IMAGE_WIDTH+col.
   logic [ADDR_W-1:0]   base_q,      base_d;
   logic [RES_W-1:0]    res_cnt_q,   res_cnt_d;

   logic                last_col;
   logic                last_win;
   logic [ADDR_W-1:0]   base_next;
   logic [CNT_W-1:0]    fill_idx;

   assign last_col = (col_q == COL_W'(OUT_W - 1));
   assign last_win = last_col && (row_q == ROW_W'(OUT_H - 1));
   // At the last column the base is row*W + W-K.
   // Adding K lands on (row+1)*W, the start of the next row of windows.
   assign base_next = last_col ? base_q + ADDR_W'(K) : base_q + ADDR_W'(1);
   // Data arriving in FETCH step c belongs to the address issued in step c-1.
   assign fill_idx  = cnt_q - CNT_W'(1);

   always_comb begin
      // NOTE: every _d starts from its _q (or an idle value), so no path leaves a latch.
      state_d     = state_q;
      done_d      = 1'b0;
      kern_addr_d = kern_addr_q;
      kern_load_d = 1'b0;
      kern_idx_d  = kern_idx_q;
      img_addr_d  = img_addr_q;
      win_valid_d = win_valid_q;
      win_pix_d   = win_pix_q;
      out_we_d    = 1'b0;
      out_addr_d  = out_addr_q;
      cnt_d       = cnt_q;
      dc_d        = dc_q;
      col_d       = col_q;
      row_d       = row_q;
      base_d      = base_q;
      res_cnt_d   = res_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_KLOAD;
               cnt_d       = '0;
               kern_addr_d = '0;
               col_d       = '0;
               row_d       = '0;
               base_d      = '0;
               res_cnt_d   = '0;
            end
         end

         S_KLOAD: begin
            // kern_load trails each address by one cycle (BRAM read latency).
            if (cnt_q != CNT_W'(KK)) begin
               kern_load_d = 1'b1;
               kern_idx_d  = kern_addr_q;
            end
            if (cnt_q < CNT_W'(KK - 1)) begin
               kern_addr_d = kern_addr_q + KADDR_W'(1);
            end else begin
               kern_addr_d = '0;
            end
            if (cnt_q == CNT_W'(KK)) begin
               state_d    = S_FETCH;
               cnt_d      = '0;
               dc_d       = '0;
               img_addr_d = base_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_FETCH: begin
            if (cnt_q != '0) begin
               win_pix_d[fill_idx*PIX_W +: PIX_W] = img_data;
            end
            // The last address is held, so nothing past the window is issued.
            if (cnt_q < CNT_W'(KK - 1)) begin
               if (dc_q == CNT_W'(K - 1)) begin
                  dc_d       = '0;
                  img_addr_d = img_addr_q + ADDR_W'(IMAGE_WIDTH - K + 1);
               end else begin
                  dc_d       = dc_q + CNT_W'(1);
                  img_addr_d = img_addr_q + ADDR_W'(1);
               end
            end
            if (cnt_q == CNT_W'(KK)) begin
               state_d     = S_PRESENT;
               win_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_PRESENT: begin
            if (win_ready) begin
               win_valid_d = 1'b0;
               if (last_win) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d    = S_FETCH;
                  cnt_d      = '0;
                  dc_d       = '0;
                  base_d     = base_next;
                  img_addr_d = base_next;
                  if (last_col) begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end

         S_DRAIN: begin
            // res_cnt_q reaches TOTAL together with the final out_we/done.
            if (res_cnt_q == RES_W'(TOTAL)) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Result path runs alongside the window walk once kernels are loaded.
      if ((state_q == S_FETCH || state_q == S_PRESENT || state_q == S_DRAIN) &&
          res_valid && (res_cnt_q != RES_W'(TOTAL))) begin
         out_we_d   = 1'b1;
         out_addr_d = ADDR_W'(res_cnt_q);
         res_cnt_d  = res_cnt_q + RES_W'(1);
         done_d     = (res_cnt_q == RES_W'(TOTAL - 1));
      end

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: state and window registers use <= and are all cleared by rst, so an abort leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         kern_addr_q <= '0;
         kern_load_q <= 1'b0;
         kern_idx_q  <= '0;
         img_addr_q  <= '0;
         win_valid_q <= 1'b0;
         win_pix_q   <= '0;
         out_we_q    <= 1'b0;
         out_addr_q  <= '0;
         cnt_q       <= '0;
         dc_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
         base_q      <= '0;
         res_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         kern_addr_q <= kern_addr_d;
         kern_load_q <= kern_load_d;
         kern_idx_q  <= kern_idx_d;
         img_addr_q  <= img_addr_d;
         win_valid_q <= win_valid_d;
         win_pix_q   <= win_pix_d;
         out_we_q    <= out_we_d;
         out_addr_q  <= out_addr_d;
         cnt_q       <= cnt_d;
         dc_q        <= dc_d;
         col_q       <= col_d;
         row_q       <= row_d;
         base_q      <= base_d;
         res_cnt_q   <= res_cnt_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign kern_addr  = kern_addr_q;
   assign kern_load  = kern_load_q;
   assign kern_idx   = kern_idx_q;
   assign img_addr   = img_addr_q;
   assign win_valid  = win_valid_q;
   assign win_pixels = win_pix_q;
   assign out_we     = out_we_q;
   assign out_addr   = out_addr_q;

endmodule
